// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared DA constants, state encoding and width helpers
package da_pkg;

    localparam int DA_DATA_WIDTH_A = 16;
    localparam int DA_DATA_WIDTH_B = 16;
    localparam int DA_K            = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } da_state_e;

    // LUT partial sums grow by log2(K) bits over the weight width.
    function automatic int da_lut_width(input int wb, input int k);
        return wb + $clog2(k);
    endfunction

    // Shifted LUT terms, the negated MSB term and the offset all fit without wrap.
    function automatic int da_acc_width(input int wa, input int wb, input int k);
        return da_lut_width(wb, k) + wa + 2;
    endfunction

endpackage

// File: rtl/da_shift_accumulator.sv
// rtl/da_shift_accumulator.sv - bit-serial OBC shift-accumulator with valid/ready result
module da_shift_accumulator
    import da_pkg::*;
#(
    parameter int DATA_WIDTH_A = DA_DATA_WIDTH_A,
    parameter int DATA_WIDTH_B = DA_DATA_WIDTH_B,
    parameter int K            = DA_K,
    parameter int LUT_WIDTH    = da_lut_width(DATA_WIDTH_B, K),
    parameter int ACC_WIDTH    = da_acc_width(DATA_WIDTH_A, DATA_WIDTH_B, K)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lut_valid,
    output logic                        lut_ready,
    input  logic signed [LUT_WIDTH:0]   LUT_out,
    input  logic        [7:0]           t,
    input  logic signed [LUT_WIDTH:0]   offset_in,
    output logic signed [ACC_WIDTH-1:0] acc_out,
    output logic                        acc_valid,
    input  logic                        acc_ready,
    output logic                        busy,
    output logic                        err_seq
);

    localparam logic [7:0] T_LAST = 8'(DATA_WIDTH_A - 1);
    localparam int         EXT    = ACC_WIDTH - LUT_WIDTH - 1;

    da_state_e                    state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic        [7:0]            exp_t_q, exp_t_d;
    logic signed [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
    logic                         acc_valid_q, acc_valid_d;
    logic                         err_seq_q, err_seq_d;

    logic                         accept;
    logic                         start;
    logic signed [ACC_WIDTH-1:0]  lut_ext, off_ext, term_shift, term;
    logic signed [ACC_WIDTH-1:0]  start_sum, accum_sum;

    assign lut_ready = (state_q != ST_HOLD) || acc_ready;
    assign accept    = lut_valid && lut_ready;

    assign lut_ext    = {{EXT{LUT_out[LUT_WIDTH]}}, LUT_out};
    assign off_ext    = {{EXT{offset_in[LUT_WIDTH]}}, offset_in};
    assign term_shift = lut_ext <<< t;
    // The MSB slice carries negative weight in two's complement.
    assign term       = (t == T_LAST) ? -term_shift : term_shift;
    assign start_sum  = term - off_ext;
    assign accum_sum  = acc_q + term;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        exp_t_d     = exp_t_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        err_seq_d   = 1'b0;
        start       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (t == 8'd0) start = 1'b1;
                    else           err_seq_d = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (t == exp_t_q) begin
                        if (t == T_LAST) begin
                            acc_out_d   = accum_sum;
                            acc_valid_d = 1'b1;
                            acc_d       = '0;
                            exp_t_d     = 8'd0;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d   = accum_sum;
                            exp_t_d = exp_t_q + 8'd1;
                        end
                    end else begin
                        err_seq_d = 1'b1;
                        acc_d     = '0;
                        exp_t_d   = 8'd0;
                        state_d   = ST_IDLE;
                        if (t == 8'd0) start = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (acc_ready) begin
                    acc_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (accept) begin
                        if (t == 8'd0) start = 1'b1;
                        else           err_seq_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A t==0 slice opens a result; with a single slice it is also the MSB.
        if (start) begin
            if (DATA_WIDTH_A == 1) begin
                acc_out_d   = start_sum;
                acc_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end else begin
                acc_d   = start_sum;
                exp_t_d = 8'd1;
                state_d = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            exp_t_q     <= 8'd0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            exp_t_q     <= exp_t_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            err_seq_q   <= err_seq_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign err_seq   = err_seq_q;
    assign busy      = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_da_shift_accumulator.sv
// tb/tb_da_shift_accumulator.sv - scoreboard bench for da_shift_accumulator, W=4
module tb_da_shift_accumulator;

    localparam int W   = 4;
    localparam int WB  = 16;
    localparam int KK  = 9;
    localparam int LW  = WB + $clog2(KK);
    localparam int AW  = LW + W + 2;
    localparam longint LMAX = (64'sd1 <<< LW) - 1;
    localparam longint LMIN = -(64'sd1 <<< LW);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 lut_valid = 1'b0;
    logic                 lut_ready;
    logic signed [LW:0]   lut_out_s = '0;
    logic        [7:0]    t_s = '0;
    logic signed [LW:0]   offset_s = '0;
    logic signed [AW-1:0] acc_out_s;
    logic                 acc_valid;
    logic                 acc_ready = 1'b1;
    logic                 busy;
    logic                 err_seq;

    int pass_cnt = 0;
    int total_cnt = 0;
    int err_seen = 0;
    int valid_beats = 0;
    longint exp_q[$];

    da_shift_accumulator #(
        .DATA_WIDTH_A(W),
        .DATA_WIDTH_B(WB),
        .K(KK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lut_valid(lut_valid),
        .lut_ready(lut_ready),
        .LUT_out(lut_out_s),
        .t(t_s),
        .offset_in(offset_s),
        .acc_out(acc_out_s),
        .acc_valid(acc_valid),
        .acc_ready(acc_ready),
        .busy(busy),
        .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic longint model4(input longint s0, input longint s1, input longint s2,
                                      input longint s3, input longint off);
        return s0 + (s1 <<< 1) + (s2 <<< 2) - (s3 <<< 3) - off;
    endfunction

    // Monitor: samples mid-low-phase, after drivers settle and before the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (err_seq) err_seen++;
                if (acc_valid && acc_ready) begin
                    valid_beats++;
                    if (exp_q.size() == 0) check("unexpected_result", longint'(acc_out_s), 0);
                    else check("acc_out", longint'(acc_out_s), exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input longint v, input int tt, input longint off, input int gap);
        bit done = 1'b0;
        repeat (gap) @(negedge clk);
        lut_valid = 1'b1;
        lut_out_s = (LW+1)'(v);
        t_s       = 8'(tt);
        offset_s  = (LW+1)'(off);
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (lut_ready) done = 1'b1;
            @(negedge clk);
        end
        lut_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send_seq(input longint s0, input longint s1, input longint s2,
                            input longint s3, input longint off, input int gap);
        send(s0, 0, off, gap);
        send(s1, 1, 0, gap);
        send(s2, 2, 0, gap);
        send(s3, 3, 0, gap);
    endtask

    task automatic wait_valid();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (acc_valid) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) check("wait_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        #1;
        check({tag, "_acc_out"}, longint'(acc_out_s), 0);
        check({tag, "_acc_valid"}, acc_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_seq"}, err_seq, 0);
        check({tag, "_lut_ready"}, lut_ready, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int e0, v0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");
        @(negedge clk);

        // Basic all-ones: 1+2+4-8 = -1, exactly one result beat.
        v0 = valid_beats;
        exp_q.push_back(-1);
        send_seq(1, 1, 1, 1, 0, 0);
        drain();
        check("single_beat", valid_beats - v0, 1);

        // Same vector with gaps 0..5: 3+0-8-40-2 = -47.
        for (int g = 0; g <= 5; g++) begin
            exp_q.push_back(-47);
            send_seq(3, 0, -2, 5, 2, g);
        end
        drain();

        // Backpressure: result held, lut_ready low, then back-to-back restart.
        acc_ready = 1'b0;
        exp_q.push_back(-47);
        send_seq(3, 0, -2, 5, 2, 0);
        wait_valid();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("hold_lut_ready", lut_ready, 0);
            check("hold_acc_out", longint'(acc_out_s), -47);
            @(negedge clk);
        end
        acc_ready = 1'b1;
        exp_q.push_back(-1);
        send_seq(1, 1, 1, 1, 0, 0);
        drain();

        // Out-of-order slice t=3 after t=1.
        e0 = err_seen;
        v0 = valid_beats;
        send(1, 0, 0, 0);
        send(1, 1, 0, 0);
        send(1, 3, 0, 0);
        repeat (3) @(negedge clk);
        check("order_err_pulse", err_seen - e0, 1);
        check("order_no_result", valid_beats - v0, 0);
        check("order_idle", busy, 0);
        exp_q.push_back(49);
        send_seq(2, -1, 3, -4, -5, 1);
        drain();

        // Non-zero slice index while idle.
        e0 = err_seen;
        send(5, 2, 0, 0);
        repeat (3) @(negedge clk);
        check("idle_err_pulse", err_seen - e0, 1);
        check("idle_stays_idle", busy, 0);

        // Extreme magnitudes.
        exp_q.push_back(model4(LMAX, LMAX, LMAX, LMIN, LMIN));
        send_seq(LMAX, LMAX, LMAX, LMIN, LMIN, 0);
        exp_q.push_back(model4(LMIN, LMIN, LMIN, LMAX, LMAX));
        send_seq(LMIN, LMIN, LMIN, LMAX, LMAX, 2);
        drain();

        // Reset mid-accumulation.
        send(7, 0, 3, 0);
        send(7, 1, 0, 0);
        pulse_reset();
        check_reset_vals("rst_accum");
        @(negedge clk);
        exp_q.push_back(-1);
        send_seq(1, 1, 1, 1, 0, 0);
        drain();

        // Reset while holding a result: that result must never appear.
        acc_ready = 1'b0;
        send_seq(3, 0, -2, 5, 2, 0);
        wait_valid();
        pulse_reset();
        check_reset_vals("rst_hold");
        acc_ready = 1'b1;
        v0 = valid_beats;
        repeat (5) @(negedge clk);
        check("rst_hold_no_valid", valid_beats - v0, 0);
        exp_q.push_back(-47);
        send_seq(3, 0, -2, 5, 2, 0);
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
